icache: RTL

- Direct-mapped, read-only instruction cache; the responder for the fetch stage's icache port.
- Accepts a fetch address, returns an aligned pair of 32-bit instructions one cycle later on a hit.
- On a miss, holds fetch with `cache_stall`, refills one line from the memory side in 32-bit beats, then returns the pair.
- Sits between fetch and the L2/memory arbiter.

---
 rtl/icache.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache returning aligned 32-bit instruction pairs
// Flop-based tag/valid/data arrays; a miss refills one line in 32-bit beats before the pair is replayed.
module icache #(
  parameter int ADDR_BITS  = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     inv,
  input  logic                     icache_re,
  input  logic [ADDR_BITS-1:0]     icache_addr,
  output logic [2*ADDR_BITS-1:0]   icache_dout,
  output logic                     icache_dout_val,
  output logic                     cache_stall,
  output logic                     mem_req_val,
  input  logic                     mem_req_rdy,
  output logic [ADDR_BITS-1:0]     mem_req_addr,
  input  logic                     mem_resp_val,
  input  logic [31:0]              mem_resp_data
);
  localparam int WB       = $clog2(LINE_WORDS);
  localparam int OFF_BITS = WB + 2;
  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS = ADDR_BITS - OFF_BITS - IDX_BITS;

  typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_FILL} state_t;

  state_t               state, state_next;
  logic [ADDR_BITS-1:0] req_addr;
  logic                 req_pending;
  logic                 drop;
  logic                 inv_pending;
  logic [WB-1:0]        count;
  logic [NUM_LINES-1:0] valid;
  logic [TAG_BITS-1:0]  tags [NUM_LINES];
  logic [31:0]          data [NUM_LINES][LINE_WORDS];

  logic [IDX_BITS-1:0]  idx;
  logic [TAG_BITS-1:0]  tag;
  logic [WB-1:0]        w_lo, w_hi;
  logic                 hit, lookup, accept, last_beat;

  assign idx       = req_addr[OFF_BITS +: IDX_BITS];
  assign tag       = req_addr[ADDR_BITS-1 -: TAG_BITS];
  assign hit       = valid[idx] && (tags[idx] == tag);
  assign lookup    = (state == IDLE) && req_pending;
  assign accept    = (state == IDLE) && !cache_stall && icache_re;
  assign last_beat = (state == MISS_FILL) && mem_resp_val && (count == WB'(LINE_WORDS - 1));

  always_comb begin
    w_lo    = req_addr[OFF_BITS-1:2];
    w_lo[0] = 1'b0;
    w_hi    = w_lo;
    w_hi[0] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next      = state;
    icache_dout_val = 1'b0;
    cache_stall     = 1'b0;
    mem_req_val     = 1'b0;
    mem_req_addr    = '0;
    case (state)
      IDLE: begin
        if (req_pending && !flush) begin
          if (hit) begin
            icache_dout_val = 1'b1;
          end else begin
            cache_stall = 1'b1;
            state_next  = MISS_REQ;
          end
        end
      end
      MISS_REQ: begin
        cache_stall  = 1'b1;
        mem_req_val  = 1'b1;
        mem_req_addr = {req_addr[ADDR_BITS-1:OFF_BITS], {OFF_BITS{1'b0}}};
        if (mem_req_rdy) state_next = MISS_FILL;
      end
      MISS_FILL: begin
        cache_stall = 1'b1;
        if (last_beat) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    icache_dout = '0;
    if (icache_dout_val) icache_dout = {data[idx][w_hi], data[idx][w_lo]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_addr    <= '0;
      req_pending <= 1'b0;
      drop        <= 1'b0;
      inv_pending <= 1'b0;
      count       <= '0;
      valid       <= '0;
    end else begin
      if (accept) begin
        req_addr    <= icache_addr;
        req_pending <= 1'b1;
      end else if (lookup && (hit || flush)) begin
        req_pending <= 1'b0;
      end else if (last_beat && (drop || flush)) begin
        req_pending <= 1'b0;
      end

      if (state != IDLE && flush) drop <= 1'b1;
      if (state != IDLE && inv)   inv_pending <= 1'b1;

      if (state == MISS_REQ) count <= '0;
      else if (state == MISS_FILL && mem_resp_val) count <= count + 1'b1;

      if (state == IDLE && inv) valid <= '0;

      // An invalidate seen at any point of the refill also discards the line just filled.
      if (last_beat) begin
        drop        <= 1'b0;
        inv_pending <= 1'b0;
        if (inv_pending || inv) valid <= '0;
        else                    valid[idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == MISS_FILL && mem_resp_val) data[idx][count] <= mem_resp_data;
    if (last_beat) tags[idx] <= tag;
  end
endmodule
